// File: rtl/eq_band_sequencer.sv
// Applies five band gains and a master volume to a stereo sample through one shared 17x13 multiplier.
// 12 clocks from the accepting edge to out_vld; a sample_vld arriving while busy is dropped and flags overrun.
module eq_band_sequencer #(
   parameter int GAIN_SHIFT = 11,
   parameter int VOL_SHIFT  = 12
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             sample_vld_i,
   input  logic [4:0][15:0] lft_band_i,
   input  logic [4:0][15:0] rght_band_i,
   input  logic [4:0][11:0] pot_gain_i,
   input  logic [11:0]      pot_vol_i,
   output logic [15:0]      lft_out_o,
   output logic [15:0]      rght_out_o,
   output logic             out_vld_o,
   output logic             busy_o,
   output logic             overrun_o
);

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      L0 = 4'd1, L1 = 4'd2, L2 = 4'd3, L3 = 4'd4, L4 = 4'd5, LV = 4'd6,
      R0 = 4'd7, R1 = 4'd8, R2 = 4'd9, R3 = 4'd10, R4 = 4'd11, RV = 4'd12
   } state_t;

   state_t              state_q;
   logic signed [31:0]  acc_q;
   logic [4:0][15:0]    lft_q;
   logic [4:0][15:0]    rght_q;
   logic [4:0][11:0]    gain_q;
   logic [11:0]         vol_q;
   logic [15:0]         hold_q;
   logic [15:0]         lft_out_q;
   logic [15:0]         rght_out_q;
   logic                out_vld_q;
   logic                busy_q;
   logic                overrun_q;

   logic [2:0]          k_d;
   logic                is_r_d;
   logic                is_vol_d;
   logic [15:0]         sat_d;
   logic signed [16:0]  op_a_d;
   logic signed [12:0]  op_b_d;
   logic signed [29:0]  prod_d;
   logic signed [31:0]  acc_d;
   logic [15:0]         y_d;

   always_comb begin
      k_d      = 3'd0;
      is_r_d   = 1'b0;
      is_vol_d = 1'b0;
      case (state_q)
         L1: k_d = 3'd1;
         L2: k_d = 3'd2;
         L3: k_d = 3'd3;
         L4: k_d = 3'd4;
         LV: is_vol_d = 1'b1;
         R0: is_r_d = 1'b1;
         R1: begin is_r_d = 1'b1; k_d = 3'd1; end
         R2: begin is_r_d = 1'b1; k_d = 3'd2; end
         R3: begin is_r_d = 1'b1; k_d = 3'd3; end
         R4: begin is_r_d = 1'b1; k_d = 3'd4; end
         RV: is_vol_d = 1'b1;
         default: k_d = 3'd0;
      endcase

      // acc >>> GAIN_SHIFT fits in 16 bits only when bits [31:26] all agree
      if (!acc_q[31] && (|acc_q[30:GAIN_SHIFT+15]))
         sat_d = 16'h7FFF;
      else if (acc_q[31] && !(&acc_q[30:GAIN_SHIFT+15]))
         sat_d = 16'h8000;
      else
         sat_d = acc_q[GAIN_SHIFT+15:GAIN_SHIFT];

      if (is_vol_d) begin
         op_a_d = {sat_d[15], sat_d};
         op_b_d = {1'b0, vol_q};
      end else if (is_r_d) begin
         op_a_d = {rght_q[k_d][15], rght_q[k_d]};
         op_b_d = {1'b0, gain_q[k_d]};
      end else begin
         op_a_d = {lft_q[k_d][15], lft_q[k_d]};
         op_b_d = {1'b0, gain_q[k_d]};
      end

      prod_d = op_a_d * op_b_d;
      acc_d  = acc_q + {{2{prod_d[29]}}, prod_d};
      y_d    = prod_d[VOL_SHIFT+15:VOL_SHIFT];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         lft_q      <= '0;
         rght_q     <= '0;
         gain_q     <= '0;
         vol_q      <= '0;
         hold_q     <= '0;
         lft_out_q  <= '0;
         rght_out_q <= '0;
         out_vld_q  <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         out_vld_q <= 1'b0;
         if (sample_vld_i && (state_q != IDLE))
            overrun_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (sample_vld_i) begin
                  lft_q   <= lft_band_i;
                  rght_q  <= rght_band_i;
                  gain_q  <= pot_gain_i;
                  vol_q   <= pot_vol_i;
                  acc_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= L0;
               end
            end
            LV: begin
               hold_q  <= y_d;
               acc_q   <= '0;
               state_q <= R0;
            end
            RV: begin
               lft_out_q  <= hold_q;
               rght_out_q <= y_d;
               out_vld_q  <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
            default: begin
               // band steps; encoding is sequential so L4->LV and R4->RV fall out of +1
               acc_q   <= acc_d;
               state_q <= state_t'(state_q + 4'd1);
            end
         endcase
      end
   end

   assign lft_out_o  = lft_out_q;
   assign rght_out_o = rght_out_q;
   assign out_vld_o  = out_vld_q;
   assign busy_o     = busy_q;
   assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_eq_band_sequencer.sv
// Self-checking bench for eq_band_sequencer: fixed vectors, corner sequences and randomized runs vs an arithmetic model.
module tb_eq_band_sequencer;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             sample_vld;
   logic [4:0][15:0] lft_band;
   logic [4:0][15:0] rght_band;
   logic [4:0][11:0] pot_gain;
   logic [11:0]      pot_vol;
   logic [15:0]      lft_out;
   logic [15:0]      rght_out;
   logic             out_vld;
   logic             busy;
   logic             overrun;

   always #5 clk = ~clk;

   eq_band_sequencer #(.GAIN_SHIFT(11), .VOL_SHIFT(12)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .sample_vld_i (sample_vld),
      .lft_band_i   (lft_band),
      .rght_band_i  (rght_band),
      .pot_gain_i   (pot_gain),
      .pot_vol_i    (pot_vol),
      .lft_out_o    (lft_out),
      .rght_out_o   (rght_out),
      .out_vld_o    (out_vld),
      .busy_o       (busy),
      .overrun_o    (overrun)
   );

   typedef struct {
      logic [4:0][15:0] lb;
      logic [4:0][15:0] rb;
      logic [4:0][11:0] g;
      logic [11:0]      v;
      logic [15:0]      el;
      logic [15:0]      er;
   } vec_t;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: weighted band sum, floor-divide by 2^11, clamp to 16b, scale by vol/2^12 (floor)
   function automatic logic [15:0] scale(input longint acc, input logic [11:0] v);
      longint s;
      longint y;
      logic [63:0] yb;
      s = acc >>> 11;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      y = (s * longint'(v)) >>> 12;
      yb = y;
      return yb[15:0];
   endfunction

   task automatic model(input vec_t t, output logic [15:0] lo, output logic [15:0] ro);
      longint sl = 0;
      longint sr = 0;
      for (int k = 0; k < 5; k++) begin
         sl += longint'($signed(t.lb[k])) * longint'(t.g[k]);
         sr += longint'($signed(t.rb[k])) * longint'(t.g[k]);
      end
      lo = scale(sl, t.v);
      ro = scale(sr, t.v);
   endtask

   // Called at posedge+1; the pulse is sampled at the next edge (the accepting edge)
   task automatic launch(input vec_t t);
      lft_band   = t.lb;
      rght_band  = t.rb;
      pot_gain   = t.g;
      pot_vol    = t.v;
      sample_vld = 1'b1;
      @(posedge clk); #1;
      sample_vld = 1'b0;
   endtask

   task automatic wait_out(input int start, output int n);
      n = start;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!out_vld && n < 40);
   endtask

   task automatic run_check(input string nm, input vec_t t, input logic [15:0] el, input logic [15:0] er);
      int n;
      launch(t);
      check({nm, " busy"}, 32'(busy), 32'd1);
      wait_out(0, n);
      check({nm, " latency"}, n, 12);
      check({nm, " lft"}, 32'(lft_out), 32'(el));
      check({nm, " rght"}, 32'(rght_out), 32'(er));
      @(posedge clk); #1;
      check({nm, " single pulse"}, 32'(out_vld), 32'd0);
      check({nm, " idle"}, 32'(busy), 32'd0);
   endtask

   vec_t tbl[6];
   vec_t t;
   vec_t unity;
   logic [15:0] el;
   logic [15:0] er;
   int n;
   int seen;

   initial begin
      rst_n      = 1'b0;
      sample_vld = 1'b0;
      lft_band   = '0;
      rght_band  = '0;
      pot_gain   = '0;
      pot_vol    = '0;

      for (int i = 0; i < 6; i++) tbl[i] = '{lb: '0, rb: '0, g: '0, v: '0, el: '0, er: '0};
      tbl[0].lb[0] = 16'h1000; tbl[0].g[0] = 12'h800; tbl[0].v = 12'hFFF;
      tbl[0].el = 16'h0FFF;    tbl[0].er = 16'h0000;
      for (int k = 0; k < 5; k++) begin
         tbl[1].lb[k] = 16'h7FFF; tbl[1].rb[k] = 16'h7FFF; tbl[1].g[k] = 12'hFFF;
         tbl[2].lb[k] = 16'h8000; tbl[2].rb[k] = 16'h8000; tbl[2].g[k] = 12'hFFF;
      end
      tbl[1].v = 12'hFFF; tbl[1].el = 16'h7FF7; tbl[1].er = 16'h7FF7;
      tbl[2].v = 12'hFFF; tbl[2].el = 16'h8008; tbl[2].er = 16'h8008;
      tbl[3].rb[2] = 16'h1000; tbl[3].g[2] = 12'h800; tbl[3].v = 12'hFFF;
      tbl[3].el = 16'h0000;    tbl[3].er = 16'h0FFF;
      tbl[4].lb[0] = 16'hF000; tbl[4].g[0] = 12'h800; tbl[4].v = 12'h800;
      tbl[4].el = 16'hF800;    tbl[4].er = 16'h0000;
      tbl[5].lb[1] = 16'h4000; tbl[5].rb[1] = 16'h4000; tbl[5].g[1] = 12'h800; tbl[5].v = 12'h000;
      tbl[5].el = 16'h0000;    tbl[5].er = 16'h0000;
      unity = tbl[0];

      repeat (2) @(posedge clk);
      #1;
      check("reset lft_out", 32'(lft_out), 32'd0);
      check("reset rght_out", 32'(rght_out), 32'd0);
      check("reset out_vld", 32'(out_vld), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) run_check($sformatf("vec%0d", i), tbl[i], tbl[i].el, tbl[i].er);

      // snapshot: pots/bands change while in L2
      launch(unity);
      @(posedge clk); #1;
      @(posedge clk); #1;
      lft_band[0] = 16'h7000;
      pot_gain[0] = 12'h000;
      wait_out(2, n);
      check("snapshot latency", n, 12);
      check("snapshot lft", 32'(lft_out), 32'h0FFF);
      check("snapshot rght", 32'(rght_out), 32'h0000);
      check("snapshot no overrun", 32'(overrun), 32'd0);
      @(posedge clk); #1;

      // reset during R1 aborts the schedule
      launch(unity);
      repeat (7) begin @(posedge clk); #1; end
      check("pre-abort busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort lft", 32'(lft_out), 32'd0);
      check("abort rght", 32'(rght_out), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      seen = 0;
      repeat (15) begin @(posedge clk); #1; if (out_vld) seen++; end
      check("abort no out_vld", seen, 0);
      run_check("after abort", unity, 16'h0FFF, 16'h0000);

      // overrun: second pulse 3 clk after the first, third on the out_vld cycle
      launch(unity);
      @(posedge clk); #1;
      @(posedge clk); #1;
      lft_band   = tbl[1].lb;
      rght_band  = tbl[1].rb;
      pot_gain   = tbl[1].g;
      sample_vld = 1'b1;
      @(posedge clk); #1;
      sample_vld = 1'b0;
      check("overrun set", 32'(overrun), 32'd1);
      wait_out(3, n);
      check("overrun latency", n, 12);
      check("overrun first lft", 32'(lft_out), 32'h0FFF);
      check("overrun first rght", 32'(rght_out), 32'h0000);
      launch(tbl[2]);
      check("third accepted busy", 32'(busy), 32'd1);
      wait_out(0, n);
      check("third latency", n, 12);
      check("third lft", 32'(lft_out), 32'h8008);
      check("third rght", 32'(rght_out), 32'h8008);
      check("overrun sticky", 32'(overrun), 32'd1);
      @(posedge clk); #1;

      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < 5; k++) begin
            case ($urandom_range(0, 3))
               0: t.lb[k] = 16'h7FFF;
               1: t.lb[k] = 16'h8000;
               default: t.lb[k] = 16'($urandom);
            endcase
            t.rb[k] = 16'($urandom);
            t.g[k]  = ($urandom_range(0, 1) == 1) ? 12'($urandom) : 12'($urandom_range(0, 12'h900));
         end
         t.v = 12'($urandom);
         model(t, el, er);
         run_check($sformatf("rand%0d", i), t, el, er);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
